// File: rtl/ota_pdm_reader.sv
// First-order sinc readout of the OTA/comparator bit: synchronise, count ones over a
// 2**WIN_LOG2 tick window, publish a saturated duty-cycle code with valid/ack.
//
// state  | meaning
// IDLE   | waiting for start&en, divider and counters held clear
// SETTLE | discarding SETTLE sample ticks after start
// ACCUM  | adding the synced bit on every sample tick
// DONE   | one cycle: publish result, restart (cont) or return to IDLE
module ota_pdm_reader #(
    parameter int WIN_LOG2    = 8,
    parameter int SAMPLE_DIV  = 4,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cmp_in,
    input  logic                start,
    input  logic                cont,
    input  logic                ack,
    output logic [WIN_LOG2-1:0] result,
    output logic                valid,
    output logic                busy,
    output logic                overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = (WIN_LOG2 > SW) ? WIN_LOG2 : SW;

    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] ACC_LOAD = TW'((1 << WIN_LOG2) - 1);
    localparam logic [TW-1:0] SET_LOAD = TW'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          div;
    logic                   tick;
    logic [TW-1:0]          tcnt;
    logic [WIN_LOG2:0]      count;
    logic                   bit_s;
    logic [WIN_LOG2-1:0]    sat;
    logic                   write;

    assign bit_s = sync[SYNC_STAGES-1];
    assign sat   = count[WIN_LOG2] ? {WIN_LOG2{1'b1}} : count[WIN_LOG2-1:0];
    assign write = (state == S_DONE) && en;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // Tick is registered, so the FSM acts one cycle after the divider terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (state == S_IDLE || !en) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= (div == DIV_LAST) ? '0 : div + 1'b1;
            tick <= (div == DIV_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tcnt  <= '0;
            count <= '0;
        end else if (!en) begin
            state <= S_IDLE;
            tcnt  <= '0;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= '0;
                    if (start) begin
                        if (SETTLE == 0) begin
                            state <= S_ACCUM;
                            tcnt  <= ACC_LOAD;
                        end else begin
                            state <= S_SETTLE;
                            tcnt  <= SET_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    if (tick) begin
                        if (tcnt == '0) begin
                            state <= S_ACCUM;
                            tcnt  <= ACC_LOAD;
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (tick) begin
                        count <= count + {{WIN_LOG2{1'b0}}, bit_s};
                        if (tcnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            tcnt <= tcnt - 1'b1;
                        end
                    end
                end
                default: begin
                    count <= '0;
                    if (cont) begin
                        state <= S_ACCUM;
                        tcnt  <= ACC_LOAD;
                    end else begin
                        state <= S_IDLE;
                        tcnt  <= '0;
                    end
                end
            endcase
        end
    end

    // An ack coinciding with a write retires the old value; the new one stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (write) begin
            result <= sat;
            valid  <= 1'b1;
            if (valid && !ack) begin
                overrun <= 1'b1;
            end
        end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ota_pdm_reader.sv
// Directed bench for ota_pdm_reader with WIN_LOG2=4, SAMPLE_DIV=2, SETTLE=2.
module tb_ota_pdm_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cmp_in;
    logic       start;
    logic       cont;
    logic       ack;
    logic [3:0] result;
    logic       valid;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = 0;

    ota_pdm_reader #(
        .WIN_LOG2(4), .SAMPLE_DIV(2), .SETTLE(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in), .start(start),
        .cont(cont), .ack(ack), .result(result), .valid(valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Comparator pattern generator: 0, 1, 50% (2 clk per level), 25% (2 of 8 clk).
    initial begin
        logic [2:0] ph;
        ph     = '0;
        cmp_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = ph + 3'd1;
            case (mode)
                0:       cmp_in = 1'b0;
                1:       cmp_in = 1'b1;
                2:       cmp_in = ph[1];
                default: cmp_in = (ph[2:1] == 2'd0);
            endcase
        end
    end

    typedef struct {
        int         mode;
        logic [3:0] exp_result;
        string      name;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // cyc becomes k at the negedge following the k-th posedge after the start edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_valid(input string name);
        while (!valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 37) begin
                chk({name, "_busy37"}, busy, 1);
                chk({name, "_valid37"}, valid, 0);
            end
        end
        chk({name, "_latency"}, cyc, 38);
    endtask

    initial begin
        vecs[0] = '{1, 4'd15, "ones"};
        vecs[1] = '{0, 4'd0,  "zeros"};
        vecs[2] = '{2, 4'd8,  "half"};
        vecs[3] = '{3, 4'd4,  "quarter"};

        rst = 1'b1; en = 1'b1; start = 1'b0; cont = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            pulse_ack();
            pulse_start();
            wait_valid(vecs[i].name);
            chk({vecs[i].name, "_result"}, result, vecs[i].exp_result);
            chk({vecs[i].name, "_busy_after"}, busy, 0);
            chk({vecs[i].name, "_overrun"}, overrun, 0);
        end

        // Continuous mode, overrun and ack corner cases.
        mode = 1;
        pulse_ack();
        cont = 1'b1;
        pulse_start();
        wait_valid("cont1");
        chk("cont1_overrun", overrun, 0);
        wait_to(69);
        chk("cont69_valid", valid, 1);
        chk("cont69_overrun", overrun, 0);
        wait_to(70);
        chk("cont70_overrun", overrun, 1);
        chk("cont70_result", result, 15);
        chk("cont70_busy", busy, 1);
        ack = 1'b1;
        wait_to(71);
        ack = 1'b0;
        chk("ack_valid", valid, 0);
        chk("ack_overrun", overrun, 0);
        wait_to(101);
        chk("cont101_valid", valid, 0);
        wait_to(102);
        chk("cont102_valid", valid, 1);
        chk("cont102_overrun", overrun, 0);
        wait_to(133);
        ack = 1'b1;
        wait_to(134);
        ack = 1'b0;
        chk("ackwrite_valid", valid, 1);
        chk("ackwrite_overrun", overrun, 0);
        cont = 1'b0;
        wait_to(166);
        chk("contoff_busy", busy, 0);
        chk("contoff_valid", valid, 1);
        chk("contoff_overrun", overrun, 1);

        // Reset mid-accumulation, then a fresh conversion.
        pulse_ack();
        pulse_start();
        wait_to(27);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_result", result, 15);
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        wait_valid("postrst");
        chk("postrst_result", result, 15);

        // en dropped mid-ACCUM with result 15 held and unacknowledged.
        mode = 0;
        pulse_start();
        wait_to(20);
        chk("pre_en_busy", busy, 1);
        en = 1'b0;
        wait_to(21);
        chk("endrop_busy", busy, 0);
        chk("endrop_result", result, 15);
        chk("endrop_valid", valid, 1);
        start = 1'b1;
        wait_to(22);
        start = 1'b0;
        wait_to(23);
        chk("en_low_start_busy", busy, 0);
        wait_to(70);
        chk("endrop_late_result", result, 15);
        chk("endrop_late_valid", valid, 1);
        chk("endrop_late_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
